virq_arbiter: RTL and testbench
===============================

// Module: virq_arbiter
// PURPOSE
//  Arbitrates the peripheral vectored-interrupt request lines (keyboard virq_req60/virq_req274, timer, etc.) onto one CPU IRQ.
//  Runs the CPU interrupt-acknowledge handshake, returns the winner's vector and drives the winner's virq_ack.
//  Holds virq_ack until the requester drops its req, or until a timeout expires.
//  Sits between the peripherals on the wishbone bus and the CPU core, in the wb_clk domain.
// PARAMETERS
//  NREQ     4    number of request lines; index 0 = highest fixed priority
//  VEC_W    9    width of each vector (byte address, e.g. 9'o060, 9'o274)
//  ACK_TMO  255  max wb_clk cycles virq_ack is held waiting for req to drop
// PORTS
//  wb_clk        in   1            system clock, all logic on posedge
//  sys_init      in   1            async active-high reset
//  virq_req      in   NREQ         level requests from peripherals
//  virq_ack      out  NREQ         one-hot acknowledge to the winning peripheral
//  virq_vec      in   NREQ*VEC_W   packed vectors; slice i = vector of req i
//  irq_mask      in   1            CPU priority mask; 1 blocks new IRQ presentation
//  cpu_irq       out  1            interrupt request to CPU
//  cpu_iack_stb  in   1            CPU interrupt-acknowledge cycle strobe (level, held until ack)
//  cpu_iack_ack  out  1            acknowledge for the iack cycle
//  cpu_ivec      out  16           vector returned to CPU, zero-extended from VEC_W
// BEHAVIOUR
//  Reset (async, sys_init=1):
//   - outputs: virq_ack=0, cpu_irq=0, cpu_iack_ack=0, cpu_ivec=0
//   - state: FSM=IDLE, win=0, tmo=0, rr_ptr=0
//  FSM states: IDLE, PEND, ACK, GAP.
//  IDLE:
//   - if (|virq_req) && !irq_mask: latch winner index in win, cpu_irq<=1, go PEND
//   - cpu_irq is asserted 1 cycle after the req is seen
//   - cpu_iack_stb seen in IDLE (spurious): cpu_iack_ack<=1, cpu_ivec<=0, no virq_ack, stay IDLE until stb drops
//  PEND:
//   - virq_req[win] falls (withdrawn) or irq_mask rises: cpu_irq<=0, go IDLE; re-arbitration starts next cycle
//   - rising cpu_iack_stb: cpu_ivec<=virq_vec[win]; cpu_iack_ack<=1; virq_ack[win]<=1; cpu_irq<=0; tmo<=0; go ACK
//   - iack wins over a same-cycle req withdrawal: the vector is still delivered
//  ACK:
//   - cpu_iack_ack follows cpu_iack_stb; drops 1 cycle after stb falls; cpu_ivec holds until then
//   - virq_ack[win] held until virq_req[win]==0 or tmo==ACK_TMO, whichever comes first; then virq_ack<=0
//   - leave ACK only when both virq_ack and cpu_iack_ack are 0; then go GAP
//   - tmo saturates at ACK_TMO and never wraps
//  GAP: one idle cycle with all handshake outputs 0, then IDLE. Guarantees the ack low-time before the next ack edge, since peripherals clear on the ack rising edge.
//  Requests arriving during PEND/ACK/GAP are not lost: req is a level and is re-sampled in IDLE.
//  At most one virq_ack bit is set at any time.
//  Fixed priority: lowest set index of virq_req wins.
// CONFIGURATION
//  VIRQ_ROUND_ROBIN_EN defined:
//   - winner = first set req at or after rr_ptr, searching circularly
//   - on entering ACK, rr_ptr <= win+1 (mod NREQ)
//   - rr_ptr is reset to 0
//  VIRQ_ROUND_ROBIN_EN undefined: fixed priority as above; rr_ptr logic absent.
// TESTING
//  1. virq_req=4'b0001, vec0=9'o060 -> cpu_irq=1 next cycle; iack_stb -> cpu_ivec=16'o000060, iack_ack=1, virq_ack=4'b0001.
//     Drop req -> virq_ack=0 next cycle.
//  2. virq_req=4'b0011 together, vec1=9'o274, fixed priority -> vector 060 first; req0 drops -> GAP, then vector 274 served.
//  3. Requester never drops req -> virq_ack held exactly ACK_TMO cycles, then 0; GAP; FSM re-arbitrates same req.
//  4. req0 withdrawn in PEND before iack -> cpu_irq=0 within 1 cycle, no virq_ack.
//     A later iack_stb -> iack_ack=1 with cpu_ivec=0.
//  5. irq_mask=1 with virq_req=4'b0100 -> cpu_irq stays 0; mask to 0 -> cpu_irq=1 next cycle.
//     sys_init pulse mid-ACK -> all outputs 0 immediately.
//  6. VIRQ_ROUND_ROBIN_EN, req=4'b0011 held, 4 iack cycles -> winners 0,1,0,1.

Source files
------------

// File: rtl/virq_arbiter.sv
// Vectored-interrupt arbiter: fixed-priority or round-robin (VIRQ_ROUND_ROBIN_EN)
// selection of peripheral requests onto one CPU IRQ with the iack handshake.
module virq_arbiter #(
   parameter int NREQ    = 4,
   parameter int VEC_W   = 9,
   parameter int ACK_TMO = 255
) (
   input  logic                    wb_clk,
   input  logic                    sys_init,
   input  logic [NREQ-1:0]         virq_req,
   output logic [NREQ-1:0]         virq_ack,
   input  logic [NREQ*VEC_W-1:0]   virq_vec,
   input  logic                    irq_mask,
   output logic                    cpu_irq,
   input  logic                    cpu_iack_stb,
   output logic                    cpu_iack_ack,
   output logic [15:0]             cpu_ivec
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = $clog2(ACK_TMO + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(ACK_TMO);

   typedef enum logic [1:0] {IDLE, PEND, ACK, GAP} state_t;

   state_t            state, state_n;
   logic [IW-1:0]     win, win_n, pick;
   logic [TW-1:0]     tmo, tmo_n, tmo_inc;
   logic [NREQ-1:0]   ack_n;
   logic              irq_n, iack_n;
   logic [15:0]       ivec_n;
   logic [VEC_W-1:0]  vec_sel;

   assign vec_sel = virq_vec[win*VEC_W +: VEC_W];
   assign tmo_inc = (tmo == TMO_MAX) ? tmo : tmo + 1'b1;

`ifdef VIRQ_ROUND_ROBIN_EN
   logic [IW-1:0] rr_ptr, rr_n;
   logic          found;

   // Circular search starting at the pointer left by the last grant
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         int j;
         j = (int'(rr_ptr) + k) % NREQ;
         if (!found && virq_req[j]) begin
            pick  = IW'(j);
            found = 1'b1;
         end
      end
   end
`else
   always_comb begin
      pick = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (virq_req[k]) pick = IW'(k);
      end
   end
`endif

   always_comb begin
      state_n = state;
      win_n   = win;
      tmo_n   = tmo;
      ack_n   = virq_ack;
      irq_n   = cpu_irq;
      iack_n  = cpu_iack_ack;
      ivec_n  = cpu_ivec;
`ifdef VIRQ_ROUND_ROBIN_EN
      rr_n    = rr_ptr;
`endif
      unique case (state)
         IDLE: begin
            ack_n  = '0;
            irq_n  = 1'b0;
            ivec_n = '0;
            // A strobe with nothing pending is answered with vector 0
            if (cpu_iack_stb) begin
               iack_n = 1'b1;
            end else begin
               iack_n = 1'b0;
               if ((|virq_req) && !irq_mask) begin
                  win_n   = pick;
                  irq_n   = 1'b1;
                  state_n = PEND;
               end
            end
         end
         PEND: begin
            if (cpu_iack_stb) begin
               ivec_n  = 16'(vec_sel);
               iack_n  = 1'b1;
               ack_n   = NREQ'(1) << win;
               irq_n   = 1'b0;
               tmo_n   = '0;
               state_n = ACK;
`ifdef VIRQ_ROUND_ROBIN_EN
               rr_n    = IW'((int'(win) + 1) % NREQ);
`endif
            end else if (!virq_req[win] || irq_mask) begin
               irq_n   = 1'b0;
               state_n = IDLE;
            end
         end
         ACK: begin
            iack_n = cpu_iack_stb;
            if (!cpu_iack_stb) ivec_n = '0;
            if (|virq_ack) begin
               tmo_n = tmo_inc;
               if (!virq_req[win] || tmo_inc == TMO_MAX) ack_n = '0;
            end
            if (!(|virq_ack) && !cpu_iack_ack) state_n = GAP;
         end
         GAP: begin
            ack_n   = '0;
            irq_n   = 1'b0;
            iack_n  = 1'b0;
            ivec_n  = '0;
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk or posedge sys_init) begin
      if (sys_init) begin
         state        <= IDLE;
         win          <= '0;
         tmo          <= '0;
         virq_ack     <= '0;
         cpu_irq      <= 1'b0;
         cpu_iack_ack <= 1'b0;
         cpu_ivec     <= '0;
`ifdef VIRQ_ROUND_ROBIN_EN
         rr_ptr       <= '0;
`endif
      end else begin
         state        <= state_n;
         win          <= win_n;
         tmo          <= tmo_n;
         virq_ack     <= ack_n;
         cpu_irq      <= irq_n;
         cpu_iack_ack <= iack_n;
         cpu_ivec     <= ivec_n;
`ifdef VIRQ_ROUND_ROBIN_EN
         rr_ptr       <= rr_n;
`endif
      end
   end

endmodule

// File: tb/tb_virq_arbiter.sv
// Scoreboard bench for virq_arbiter: iack transactions are queued by the
// stimulus and checked by an independent monitor on the falling clock edge.
module tb_virq_arbiter;

   logic        wb_clk = 1'b0;
   logic        sys_init = 1'b1;
   logic [3:0]  virq_req = '0;
   logic [3:0]  virq_ack;
   logic [35:0] virq_vec;
   logic        irq_mask = 1'b0;
   logic        cpu_irq;
   logic        cpu_iack_stb = 1'b0;
   logic        cpu_iack_ack;
   logic [15:0] cpu_ivec;

   typedef struct packed {
      logic [15:0] vec;
      logic [3:0]  ack;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   ack_cnt = 0;
   int   last_len = 0;
   logic iack_prev = 1'b0;

   virq_arbiter dut (
      .wb_clk       (wb_clk),
      .sys_init     (sys_init),
      .virq_req     (virq_req),
      .virq_ack     (virq_ack),
      .virq_vec     (virq_vec),
      .irq_mask     (irq_mask),
      .cpu_irq      (cpu_irq),
      .cpu_iack_stb (cpu_iack_stb),
      .cpu_iack_ack (cpu_iack_ack),
      .cpu_ivec     (cpu_ivec)
   );

   always #5 wb_clk = ~wb_clk;

   // Monitor: pops one expected transaction per iack_ack rising edge
   always @(negedge wb_clk) begin
      if (cpu_iack_ack && !iack_prev) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_iack vec=%o ack=%b", cpu_ivec, virq_ack);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (cpu_ivec !== e.vec || virq_ack !== e.ack) begin
               bad++;
               $display("FAIL iack_txn got vec=%o ack=%b want vec=%o ack=%b",
                        cpu_ivec, virq_ack, e.vec, e.ack);
            end
         end
      end
      iack_prev = cpu_iack_ack;
      if (virq_ack != 0) begin
         total++;
         if (!$onehot(virq_ack)) begin
            bad++;
            $display("FAIL ack_onehot got %b want one-hot", virq_ack);
         end
         ack_cnt++;
      end else if (ack_cnt != 0) begin
         last_len = ack_cnt;
         ack_cnt  = 0;
      end
   end

   task automatic tick(int n);
      repeat (n) @(posedge wb_clk);
      #1;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic wait_irq();
      int n = 0;
      while (!cpu_irq && n < 20) begin
         tick(1);
         n++;
      end
      chk("irq_wait", 32'(cpu_irq), 1);
   endtask

   task automatic wait_ack_low(int lim);
      int n = 0;
      while (virq_ack != 0 && n < lim) begin
         tick(1);
         n++;
      end
      chk("ack_low_wait", 32'(virq_ack), 0);
   endtask

   task automatic do_iack(logic [15:0] v, logic [3:0] a);
      int n = 0;
      exp_q.push_back('{vec: v, ack: a});
      cpu_iack_stb = 1'b1;
      do begin
         tick(1);
         n++;
      end while (!cpu_iack_ack && n < 10);
      chk("iack_rise", 32'(cpu_iack_ack), 1);
      cpu_iack_stb = 1'b0;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (cpu_iack_ack && n < 10);
      chk("iack_fall", 32'(cpu_iack_ack), 0);
      chk("ivec_clear", 32'(cpu_ivec), 0);
   endtask

   initial begin
      logic [15:0] v1, v2;
      logic [3:0]  a1, a2;
      logic [15:0] rr_v[4];
      logic [3:0]  rr_a[4];
      virq_vec = {9'o200, 9'o100, 9'o274, 9'o060};

      // reset state
      tick(3);
      chk("rst_ack", 32'(virq_ack), 0);
      chk("rst_irq", 32'(cpu_irq), 0);
      chk("rst_iack", 32'(cpu_iack_ack), 0);
      chk("rst_ivec", 32'(cpu_ivec), 0);
      sys_init = 1'b0;
      tick(2);

      // 1: single request, release on req drop
      virq_req = 4'b0001;
      tick(1);
      chk("t1_irq", 32'(cpu_irq), 1);
      do_iack(16'o060, 4'b0001);
      chk("t1_irq_low", 32'(cpu_irq), 0);
      chk("t1_ack_held", 32'(virq_ack), 4'b0001);
      virq_req = 4'b0000;
      tick(1);
      chk("t1_ack_drop", 32'(virq_ack), 0);
      tick(3);

      // 2: two simultaneous requests
`ifdef VIRQ_ROUND_ROBIN_EN
      v1 = 16'o274; a1 = 4'b0010; v2 = 16'o060; a2 = 4'b0001;
`else
      v1 = 16'o060; a1 = 4'b0001; v2 = 16'o274; a2 = 4'b0010;
`endif
      virq_req = 4'b0011;
      wait_irq();
      do_iack(v1, a1);
      virq_req = 4'b0011 & ~a1;
      tick(1);
      chk("t2_ack_drop", 32'(virq_ack), 0);
      wait_irq();
      do_iack(v2, a2);
      virq_req = 4'b0000;
      wait_ack_low(5);
      tick(3);

      // 3: requester never drops -> timeout
      virq_req = 4'b0100;
      wait_irq();
      do_iack(16'o100, 4'b0100);
      wait_ack_low(300);
      tick(1);
      chk("t3_ack_len", 32'(last_len), 255);
      wait_irq();
      do_iack(16'o100, 4'b0100);
      virq_req = 4'b0000;
      wait_ack_low(5);
      tick(3);

      // 4: withdrawal before iack, then spurious iack
      virq_req = 4'b0001;
      tick(1);
      chk("t4_irq", 32'(cpu_irq), 1);
      virq_req = 4'b0000;
      tick(1);
      chk("t4_irq_drop", 32'(cpu_irq), 0);
      chk("t4_no_ack", 32'(virq_ack), 0);
      tick(2);
      do_iack(16'o000, 4'b0000);
      tick(2);

      // 4b: iack beats a same-cycle withdrawal
      virq_req = 4'b0010;
      tick(1);
      chk("t4b_irq", 32'(cpu_irq), 1);
      virq_req = 4'b0000;
      do_iack(16'o274, 4'b0010);
      wait_ack_low(5);
      tick(3);

      // 5: mask, then async reset mid-ACK
      irq_mask = 1'b1;
      virq_req = 4'b0100;
      tick(3);
      chk("t5_masked", 32'(cpu_irq), 0);
      irq_mask = 1'b0;
      tick(1);
      chk("t5_unmasked", 32'(cpu_irq), 1);
      do_iack(16'o100, 4'b0100);
      chk("t5_ack_before_rst", 32'(virq_ack), 4'b0100);
      sys_init = 1'b1;
      #1;
      chk("t5_rst_ack", 32'(virq_ack), 0);
      chk("t5_rst_irq", 32'(cpu_irq), 0);
      chk("t5_rst_iack", 32'(cpu_iack_ack), 0);
      chk("t5_rst_ivec", 32'(cpu_ivec), 0);
      virq_req = 4'b0000;
      tick(2);
      sys_init = 1'b0;
      tick(2);

      // 6: two held requests, four grants
`ifdef VIRQ_ROUND_ROBIN_EN
      rr_v = '{16'o060, 16'o274, 16'o060, 16'o274};
      rr_a = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
`else
      rr_v = '{16'o060, 16'o060, 16'o060, 16'o060};
      rr_a = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
      virq_req = 4'b0011;
      for (int i = 0; i < 4; i++) begin
         wait_irq();
         do_iack(rr_v[i], rr_a[i]);
         wait_ack_low(300);
         tick(1);
      end
      virq_req = 4'b0000;
      tick(5);

      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
